// File: rtl/div_top.sv
// div_top -- iterative restoring divider, one quotient bit per clock.
//
// Divides a 2*WIDTH-bit dividend by a WIDTH-bit divisor and returns a
// WIDTH-bit quotient and remainder. Valid/ready handshakes on both sides.
// Only one operation is in flight at a time.
//
// Ports:
//   clk          system clock, all state on rising edge
//   rst_n        asynchronous active-low reset
//   in_valid     dividend/divisor present
//   in_ready     block idle and able to accept
//   p_in         dividend (2*WIDTH bits)
//   y            divisor (WIDTH bits)
//   out_valid    result held on outputs
//   out_ready    consumer accepts result
//   q_out        quotient (all ones on divide-by-zero or overflow)
//   r_out        remainder (truncated, even when rounding is enabled)
//   div_by_zero  y was 0 for this result
//   overflow     quotient does not fit in WIDTH bits
//
// Build option:
//   DIV_ROUND_EN  when defined, the quotient is rounded half up and
//                 saturates at all ones; latency is unchanged.

module div_top #(
    parameter int unsigned WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2*WIDTH-1:0]   p_in,
    input  logic [WIDTH-1:0]     y,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     q_out,
    output logic [WIDTH-1:0]     r_out,
    output logic                 div_by_zero,
    output logic                 overflow
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH:0]   rem_q, rem_d;      // partial remainder, one spare bit
    logic [WIDTH-1:0] lo_q, lo_d;        // remaining low dividend bits
    logic [WIDTH-1:0] quo_q, quo_d;      // quotient accumulator
    logic [WIDTH-1:0] y_q, y_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] q_out_q, q_out_d;
    logic [WIDTH-1:0] r_out_q, r_out_d;
    logic             dbz_q, dbz_d;
    logic             ovf_q, ovf_d;

    logic [WIDTH:0]   trial;
    logic [WIDTH:0]   diff;
    logic             qbit;
    logic [WIDTH-1:0] q_final;
    logic [WIDTH-1:0] q_res;
`ifdef DIV_ROUND_EN
    logic             round_up;
`endif

    // One restoring step: shift in the next dividend bit, subtract if it fits.
    // rem_q < y_q always holds, so only its low WIDTH bits carry information.
    always_comb begin
        trial   = {rem_q[WIDTH-1:0], lo_q[WIDTH-1]};
        qbit    = (trial >= {1'b0, y_q});
        diff    = qbit ? (trial - {1'b0, y_q}) : trial;
        q_final = (quo_q << 1) | WIDTH'(qbit);
`ifdef DIV_ROUND_EN
        // Round half up on the final remainder; never wrap past all ones.
        round_up = ({diff, 1'b0} >= {2'b00, y_q});
        q_res    = (round_up && (q_final != '1)) ? (q_final + WIDTH'(1)) : q_final;
`else
        q_res    = q_final;
`endif
    end

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        lo_d    = lo_q;
        quo_d   = quo_q;
        y_d     = y_q;
        cnt_d   = cnt_q;
        q_out_d = q_out_q;
        r_out_d = r_out_q;
        dbz_d   = dbz_q;
        ovf_d   = ovf_q;

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    y_d = y;
                    if (y == '0) begin
                        q_out_d = '1;
                        r_out_d = '0;
                        dbz_d   = 1'b1;
                        ovf_d   = 1'b0;
                        state_d = DONE;
                    end else if (p_in[2*WIDTH-1:WIDTH] >= y) begin
                        q_out_d = '1;
                        r_out_d = '0;
                        dbz_d   = 1'b0;
                        ovf_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        rem_d   = {1'b0, p_in[2*WIDTH-1:WIDTH]};
                        lo_d    = p_in[WIDTH-1:0];
                        quo_d   = '0;
                        cnt_d   = CW'(WIDTH - 1);
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                rem_d = diff;
                lo_d  = lo_q << 1;
                quo_d = q_final;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == '0) begin
                    q_out_d = q_res;
                    r_out_d = diff[WIDTH-1:0];
                    dbz_d   = 1'b0;
                    ovf_d   = 1'b0;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rem_q   <= '0;
            lo_q    <= '0;
            quo_q   <= '0;
            y_q     <= '0;
            cnt_q   <= '0;
            q_out_q <= '0;
            r_out_q <= '0;
            dbz_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            lo_q    <= lo_d;
            quo_q   <= quo_d;
            y_q     <= y_d;
            cnt_q   <= cnt_d;
            q_out_q <= q_out_d;
            r_out_q <= r_out_d;
            dbz_q   <= dbz_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        in_ready    = (state_q == IDLE);
        out_valid   = (state_q == DONE);
        q_out       = q_out_q;
        r_out       = r_out_q;
        div_by_zero = dbz_q;
        overflow    = ovf_q;
    end

endmodule

// File: tb/tb_div_top.sv
// tb_div_top -- directed testbench for div_top with an arithmetic reference model.

module tb_div_top;

    localparam int unsigned W = 16;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           in_valid;
    logic           in_ready;
    logic [2*W-1:0] p_in;
    logic [W-1:0]   y;
    logic           out_valid;
    logic           out_ready;
    logic [W-1:0]   q_out;
    logic [W-1:0]   r_out;
    logic           div_by_zero;
    logic           overflow;

    div_top #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .p_in       (p_in),
        .y          (y),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .q_out      (q_out),
        .r_out      (r_out),
        .div_by_zero(div_by_zero),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [W-1:0] exp_q, exp_r;
    logic         exp_dz, exp_ov;
    logic         cmp_en = 1'b0;
    int unsigned  exp_lat;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    // Reference: plain integer division on the full dividend.
    task automatic model(input logic [2*W-1:0] p, input logic [W-1:0] d,
                         output logic [W-1:0] q, output logic [W-1:0] r,
                         output logic dz, output logic ov);
        longint unsigned qq, rr;
        dz = 1'b0;
        ov = 1'b0;
        if (d == 0) begin
            q  = '1;
            r  = '0;
            dz = 1'b1;
        end else if ((longint'(p) / longint'(d)) > 64'hFFFF) begin
            q  = '1;
            r  = '0;
            ov = 1'b1;
        end else begin
            qq = longint'(p) / longint'(d);
            rr = longint'(p) % longint'(d);
`ifdef DIV_ROUND_EN
            if (2 * rr >= longint'(d) && qq < 64'hFFFF) qq = qq + 1;
`endif
            q = qq[W-1:0];
            r = rr[W-1:0];
        end
    endtask

    // Whenever a result is presented it must match the model.
    always @(negedge clk) begin
        if (rst_n && cmp_en && out_valid) begin
            check("q_out", q_out, exp_q);
            check("r_out", r_out, exp_r);
            check("div_by_zero", div_by_zero, exp_dz);
            check("overflow", overflow, exp_ov);
        end
    end

    // Present operands on a falling edge; the next rising edge is the accept edge.
    task automatic launch(input logic [2*W-1:0] p, input logic [W-1:0] d, input logic ordy);
        @(negedge clk);
        check("in_ready_idle", in_ready, 1'b1);
        model(p, d, exp_q, exp_r, exp_dz, exp_ov);
        exp_lat  = (exp_dz || exp_ov) ? 0 : W;
        cmp_en   = 1'b1;
        p_in     = p;
        y        = d;
        in_valid = 1'b1;
        out_ready = ordy;
        @(posedge clk);
        #1;
    endtask

    // Count further edges until out_valid; optionally drive junk on the input meanwhile.
    task automatic wait_done(input bit junk);
        int unsigned n = 0;
        while (!out_valid && n < 100) begin
            check("in_ready_busy", in_ready, 1'b0);
            if (junk) begin
                in_valid = 1'b1;
                p_in     = $urandom;
                y        = 16'($urandom);
            end else begin
                in_valid = 1'b0;
            end
            @(posedge clk);
            #1;
            n++;
        end
        in_valid = 1'b0;
        check("latency", 64'(n), 64'(exp_lat));
    endtask

    task automatic run_div(input logic [2*W-1:0] p, input logic [W-1:0] d,
                           input int unsigned hold, input bit junk);
        launch(p, d, hold == 0);
        wait_done(junk);
        for (int unsigned i = 0; i < hold; i++) begin
            check("bp_out_valid", out_valid, 1'b1);
            check("bp_in_ready", in_ready, 1'b0);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("retire_out_valid", out_valid, 1'b0);
        check("retire_in_ready", in_ready, 1'b1);
        check("retained_q", q_out, exp_q);
        check("retained_r", r_out, exp_r);
    endtask

    logic [W-1:0] mq, mr;
    logic         mdz, mov;

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        p_in      = '0;
        y         = '0;

        // Pin the model with hand-computed values.
        model(32'd1000, 16'd7, mq, mr, mdz, mov);
`ifdef DIV_ROUND_EN
        check("model_1000_7_q", mq, 16'd143);
`else
        check("model_1000_7_q", mq, 16'd142);
`endif
        check("model_1000_7_r", mr, 16'd6);
        model(32'hFFFE0001, 16'hFFFF, mq, mr, mdz, mov);
        check("model_max_q", mq, 16'hFFFF);
        check("model_max_r", mr, 16'd0);
        check("model_max_ov", mov, 1'b0);
        model(32'h00010000, 16'd1, mq, mr, mdz, mov);
        check("model_ovf", {mov, mdz, mq}, {2'b10, 16'hFFFF});
        model(32'd5, 16'd0, mq, mr, mdz, mov);
        check("model_dbz", {mov, mdz, mq}, {2'b01, 16'hFFFF});
        model(32'd100, 16'd9, mq, mr, mdz, mov);
        check("model_100_9", {mq, mr}, {16'd11, 16'd1});

        // Reset state.
        repeat (2) @(negedge clk);
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_q", q_out, 16'd0);
        check("rst_r", r_out, 16'd0);
        check("rst_flags", {div_by_zero, overflow}, 2'b00);
        rst_n = 1'b1;

        run_div(32'd1000, 16'd7, 0, 1'b1);
        run_div(32'hFFFE0001, 16'hFFFF, 0, 1'b0);
        run_div(32'h00010000, 16'd1, 0, 1'b0);
        run_div(32'd5, 16'd0, 0, 1'b0);
        run_div(32'd100, 16'd9, 5, 1'b0);
        run_div(32'd0, 16'd3, 0, 1'b0);
        run_div(32'hFFFEFFFF, 16'hFFFF, 0, 1'b0);
        run_div(32'h80000000, 16'h8001, 0, 1'b1);
        run_div(32'h0000FFFF, 16'h0001, 2, 1'b0);

        // New operands offered while DONE retires: accepted one edge later.
        launch(32'd77, 16'd7, 1'b0);
        wait_done(1'b0);
        p_in      = 32'd200;
        y         = 16'd10;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("overlap_out_valid", out_valid, 1'b0);
        check("overlap_in_ready", in_ready, 1'b1);
        model(32'd200, 16'd10, exp_q, exp_r, exp_dz, exp_ov);
        exp_lat = W;
        @(posedge clk);
        #1;
        check("overlap_accept", in_ready, 1'b0);
        wait_done(1'b0);
        @(posedge clk);
        #1;
        check("overlap_retire", out_valid, 1'b0);

        // Asynchronous reset in the middle of a division.
        launch(32'd1000, 16'd7, 1'b1);
        in_valid = 1'b0;
        repeat (7) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_in_ready", in_ready, 1'b1);
        check("arst_out_valid", out_valid, 1'b0);
        check("arst_q", q_out, 16'd0);
        check("arst_r", r_out, 16'd0);
        check("arst_flags", {div_by_zero, overflow}, 2'b00);
        @(negedge clk);
        rst_n = 1'b1;

        run_div(32'd50, 16'd5, 0, 1'b0);
        check("final_q_50_5", q_out, 16'd10);
        check("final_r_50_5", r_out, 16'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
